// File: rtl/td4x_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : td4x_pkg
//  Brief    : Shared opcodes, FSM state encoding and instruction field
//             widths for the TD4X accumulator core.
//  Revision : 1.0  initial release
// ============================================================================
package td4x_pkg;

  // Instruction word = {opcode, immediate}; opcode is always 4 bits wide and
  // the immediate follows the data width.
  localparam int OP_W = 4;

  function automatic int instr_w(input int data_w);
    return OP_W + data_w;
  endfunction

  // Opcodes (dst <- value)
  localparam logic [OP_W-1:0] OP_ADD_A  = 4'b0000;  // A <- A + imm
  localparam logic [OP_W-1:0] OP_MOV_AB = 4'b0001;  // A <- B
  localparam logic [OP_W-1:0] OP_IN_A   = 4'b0010;  // A <- in_data
  localparam logic [OP_W-1:0] OP_MOV_AI = 4'b0011;  // A <- imm
  localparam logic [OP_W-1:0] OP_MOV_BA = 4'b0100;  // B <- A
  localparam logic [OP_W-1:0] OP_ADD_B  = 4'b0101;  // B <- B + imm
  localparam logic [OP_W-1:0] OP_IN_B   = 4'b0110;  // B <- in_data
  localparam logic [OP_W-1:0] OP_MOV_BI = 4'b0111;  // B <- imm
  localparam logic [OP_W-1:0] OP_ADD_AB = 4'b1000;  // A <- A + B
  localparam logic [OP_W-1:0] OP_OUT_B  = 4'b1001;  // out <- B
  localparam logic [OP_W-1:0] OP_HALT   = 4'b1010;  // stop execution
  localparam logic [OP_W-1:0] OP_OUT_I  = 4'b1011;  // out <- imm
  localparam logic [OP_W-1:0] OP_JC     = 4'b1100;  // jump if carry
  localparam logic [OP_W-1:0] OP_NOP    = 4'b1101;  // no operation
  localparam logic [OP_W-1:0] OP_JNC    = 4'b1110;  // jump if no carry
  localparam logic [OP_W-1:0] OP_JMP    = 4'b1111;  // unconditional jump

  // Execution state, explicit 2-bit encoding
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

endpackage : td4x_pkg
`default_nettype wire

// File: rtl/td4x_prog_mem.sv
`default_nettype none
// ============================================================================
//  Module   : td4x_prog_mem
//  Brief    : Program RAM, synchronous write port, asynchronous read port.
//  Revision : 1.0  initial release
// ============================================================================
module td4x_prog_mem
  import td4x_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int WORD_W = instr_w(4)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Store a program word; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : td4x_prog_mem
`default_nettype wire

// File: rtl/td4x_core.sv
`default_nettype none
// ============================================================================
//  Module   : td4x_core
//  Brief    : TD4-class accumulator CPU: A/B registers, output register,
//             PC, carry flag, internal program RAM, RUN/IDLE/HALTED control.
//  Revision : 1.0  initial release
// ============================================================================
module td4x_core
  import td4x_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_W-1:0]      prog_addr,
  input  logic [OP_W+DATA_W-1:0] prog_data,
  input  logic [DATA_W-1:0]      in_data,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  output logic                   running,
  output logic                   halted,
  output logic [ADDR_W-1:0]      pc,
  output logic                   carry
);

  localparam int INSTR_W = instr_w(DATA_W);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                carry_q, carry_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   out_q, out_d;
  logic                outv_q, outv_d;

  logic [INSTR_W-1:0]  instr;
  logic [OP_W-1:0]     opcode;
  logic [DATA_W-1:0]   imm;
  logic [ADDR_W-1:0]   jmp_tgt;
  logic [ADDR_W-1:0]   pc_inc;
  logic [DATA_W-1:0]   alu_src;
  logic [DATA_W-1:0]   alu_opb;
  logic [DATA_W:0]     alu_sum;
  logic [DATA_W-1:0]   alu_res;
  logic                mem_we;

  // Loading is only permitted while the core is not executing
  assign mem_we = prog_we && (state_q != ST_RUN);

  td4x_prog_mem #(
    .ADDR_W (ADDR_W),
    .WORD_W (INSTR_W)
  ) u_prog_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (prog_addr),
    .wdata_i (prog_data),
    .raddr_i (pc_q),
    .rdata_o (instr)
  );

  assign opcode = instr[INSTR_W-1:DATA_W];
  assign imm    = instr[DATA_W-1:0];
  assign pc_inc = pc_q + ADDR_W'(1);

  // Jump target: immediate widened or narrowed to the PC width
  if (ADDR_W > DATA_W) begin : g_tgt_zext
    assign jmp_tgt = {{(ADDR_W-DATA_W){1'b0}}, imm};
  end else begin : g_tgt_trunc
    assign jmp_tgt = imm[ADDR_W-1:0];
  end

  // ALU operand select: non-ADD opcodes add imm to zero, so carry-out is 0
  always_comb begin
    alu_src = '0;
    alu_opb = imm;
    case (opcode)
      OP_ADD_A:  alu_src = a_q;
      OP_ADD_B:  alu_src = b_q;
      OP_ADD_AB: begin
        alu_src = a_q;
        alu_opb = b_q;
      end
      default: ;
    endcase
  end

  assign alu_sum = {1'b0, alu_src} + {1'b0, alu_opb};
  assign alu_res = alu_sum[DATA_W-1:0];

  // Next-state: start handling when stopped, single-cycle execute when running
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    out_d   = out_q;
    outv_d  = 1'b0;
    if (state_q != ST_RUN) begin
      if (start) begin
        state_d = ST_RUN;
        pc_d    = '0;
        carry_d = 1'b0;
      end
    end else begin
      carry_d = alu_sum[DATA_W];
      pc_d    = pc_inc;
      case (opcode)
        OP_ADD_A, OP_MOV_AI, OP_ADD_AB: a_d = alu_res;
        OP_MOV_AB:                      a_d = b_q;
        OP_IN_A:                        a_d = in_data;
        OP_MOV_BA:                      b_d = a_q;
        OP_ADD_B, OP_MOV_BI:            b_d = alu_res;
        OP_IN_B:                        b_d = in_data;
        OP_OUT_B: begin
          out_d  = b_q;
          outv_d = 1'b1;
        end
        OP_OUT_I: begin
          out_d  = imm;
          outv_d = 1'b1;
        end
        OP_HALT: begin
          state_d = ST_HALTED;
          pc_d    = pc_q;
        end
        // Conditional jumps look at the carry left by the previous instruction
        OP_JC:  if (carry_q)  pc_d = jmp_tgt;
        OP_JNC: if (!carry_q) pc_d = jmp_tgt;
        OP_JMP: pc_d = jmp_tgt;
        default: ;
      endcase
    end
  end

  // Architectural state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      outv_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      out_q   <= out_d;
      outv_q  <= outv_d;
    end
  end

  assign out_data  = out_q;
  assign out_valid = outv_q;
  assign running   = (state_q == ST_RUN);
  assign halted    = (state_q == ST_HALTED);
  assign pc        = pc_q;
  assign carry     = carry_q;

endmodule : td4x_core
`default_nettype wire

// File: tb/tb_td4x_core.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_td4x_core
//  Brief    : Self-checking bench for td4x_core against an instruction-level
//             interpreter; plus a directed wide-parameter instance.
//  Revision : 1.0  initial release
// ============================================================================
module tb_td4x_core;

  localparam int DW = 4;
  localparam int AW = 4;
  localparam int DM = 1 << DW;
  localparam int AM = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic          reset, start, prog_we;
  logic [AW-1:0] prog_addr;
  logic [DW+3:0] prog_data;
  logic [DW-1:0] in_data;
  logic [DW-1:0] out_data;
  logic          out_valid, running, halted, carry;
  logic [AW-1:0] pc;

  td4x_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .running(running),
    .halted(halted), .pc(pc), .carry(carry)
  );

  // Wide instance: DATA_W=8, ADDR_W=6
  logic        reset8, start8, we8;
  logic [5:0]  addr8;
  logic [11:0] data8;
  logic [7:0]  in8;
  logic [7:0]  out8;
  logic        outv8, run8, halt8, carry8;
  logic [5:0]  pc8;

  td4x_core #(.DATA_W(8), .ADDR_W(6)) dut8 (
    .clk(clk), .reset(reset8), .start(start8), .prog_we(we8),
    .prog_addr(addr8), .prog_data(data8), .in_data(in8),
    .out_data(out8), .out_valid(outv8), .running(run8),
    .halted(halt8), .pc(pc8), .carry(carry8)
  );

  int errors = 0;
  int checks = 0;

  // Reference machine state (st: 0 idle, 1 run, 2 halted)
  int m_mem [AM];
  int m_a, m_b, m_out, m_outv, m_pc, m_c, m_st;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Interpret one clock edge of the default instance at ISA level
  task automatic model_edge();
    int op, imm, s, newc, npc, tgt;
    if (!reset) begin
      m_a = 0; m_b = 0; m_out = 0; m_outv = 0; m_pc = 0; m_c = 0; m_st = 0;
      return;
    end
    if (m_st != 1) begin
      if (prog_we) m_mem[int'(prog_addr)] = int'(prog_data);
      m_outv = 0;
      if (start) begin
        m_st = 1; m_pc = 0; m_c = 0;
      end
      return;
    end
    op   = m_mem[m_pc] / DM;
    imm  = m_mem[m_pc] % DM;
    tgt  = imm % AM;
    newc = 0;
    npc  = (m_pc + 1) % AM;
    m_outv = 0;
    case (op)
      0:  begin s = m_a + imm; newc = s / DM; m_a = s % DM; end
      1:  m_a = m_b;
      2:  m_a = int'(in_data);
      3:  m_a = imm;
      4:  m_b = m_a;
      5:  begin s = m_b + imm; newc = s / DM; m_b = s % DM; end
      6:  m_b = int'(in_data);
      7:  m_b = imm;
      8:  begin s = m_a + m_b; newc = s / DM; m_a = s % DM; end
      9:  begin m_out = m_b; m_outv = 1; end
      10: begin m_st = 2; npc = m_pc; end
      11: begin m_out = imm; m_outv = 1; end
      12: if (m_c != 0) npc = tgt;
      14: if (m_c == 0) npc = tgt;
      15: npc = tgt;
      default: ;
    endcase
    m_c  = newc;
    m_pc = npc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".out"},   out_data,  m_out);
    chk({tag, ".valid"}, out_valid, m_outv);
    chk({tag, ".pc"},    pc,        m_pc);
    chk({tag, ".carry"}, carry,     m_c);
    chk({tag, ".run"},   running,   (m_st == 1) ? 1 : 0);
    chk({tag, ".halt"},  halted,    (m_st == 2) ? 1 : 0);
  endtask

  task automatic load(input int addr, input int word);
    prog_we   = 1'b1;
    prog_addr = AW'(addr);
    prog_data = (DW+4)'(word);
    tick();
    prog_we   = 1'b0;
  endtask

  task automatic load8(input int addr, input int word);
    we8   = 1'b1;
    addr8 = 6'(addr);
    data8 = 12'(word);
    tick();
    we8   = 1'b0;
  endtask

  initial begin
    int outs[$];
    int vcyc[$];
    reset = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; in_data = '0;
    reset8 = 1'b0; start8 = 1'b0; we8 = 1'b0; addr8 = '0; data8 = '0; in8 = '0;
    m_a = 0; m_b = 0; m_out = 0; m_outv = 0; m_pc = 0; m_c = 0; m_st = 0;
    for (int i = 0; i < AM; i++) m_mem[i] = 0;

    // Reset state
    tick(); tick();
    check_all("reset");
    chk("reset.out_const", out_data, 0);
    chk("reset.run_const", running, 0);
    reset = 1'b1;

    // Carry / JNC program
    load(0, 'h33); load(1, 'h0E); load(2, 'hE0); load(3, 'hB5); load(4, 'hA0);
    start = 1'b1; tick(); start = 1'b0;
    check_all("jnc.start");
    tick(); check_all("jnc.e0");
    tick(); check_all("jnc.add");
    chk("jnc.carry_after_add", carry, 1);
    tick(); check_all("jnc.jnc");
    chk("jnc.not_taken_pc", pc, 3);
    tick(); check_all("jnc.out");
    chk("jnc.out5", out_data, 5);
    chk("jnc.valid1", out_valid, 1);
    tick(); check_all("jnc.halt");
    chk("jnc.valid_drop", out_valid, 0);
    chk("jnc.halted", halted, 1);
    chk("jnc.halt_pc", pc, 4);
    tick(); check_all("jnc.hold");

    // Counter loop, with guard stimulus during RUN
    load(0, 'h51); load(1, 'h90); load(2, 'hF0);
    start = 1'b1; tick(); start = 1'b0;
    check_all("cnt.start");
    for (int c = 0; c < 54; c++) begin
      prog_we   = (c >= 10 && c < 12);
      prog_addr = '0;
      prog_data = 8'hA0;
      start     = (c >= 20 && c < 26);
      tick();
      check_all("cnt");
      if (out_valid) begin
        outs.push_back(int'(out_data));
        vcyc.push_back(c);
      end
    end
    prog_we = 1'b0; start = 1'b0;
    chk("cnt.nouts", outs.size() >= 17, 1);
    for (int i = 0; i < 17 && i < outs.size(); i++) chk("cnt.seq", outs[i], (i + 1) % 16);
    if (vcyc.size() >= 2) chk("cnt.gap", vcyc[1] - vcyc[0], 3);

    // Reset mid-run, then restart of the same program
    reset = 1'b0; tick(); reset = 1'b1;
    check_all("rst_mid");
    chk("rst_mid.pc0", pc, 0);
    start = 1'b1; tick(); start = 1'b0;
    outs.delete();
    for (int c = 0; c < 8; c++) begin
      tick();
      check_all("restart");
      if (out_valid) outs.push_back(int'(out_data));
    end
    chk("restart.first", (outs.size() > 0) ? outs[0] : -1, 1);

    // Input path
    reset = 1'b0; tick(); reset = 1'b1;
    in_data = 4'h9;
    load(0, 'h20); load(1, 'h40); load(2, 'h90); load(3, 'hA0);
    start = 1'b1; tick(); start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      check_all("inp");
    end
    chk("inp.out9", out_data, 9);
    chk("inp.halted", halted, 1);

    // Random programs with random noise on start/prog_we/reset/in_data
    for (int r = 0; r < 6; r++) begin
      reset = 1'b0; tick(); reset = 1'b1;
      for (int a = 0; a < AM; a++) load(a, int'($urandom_range(255, 0)));
      start = 1'b1; tick(); start = 1'b0;
      check_all("rnd.start");
      for (int c = 0; c < 60; c++) begin
        in_data   = DW'($urandom);
        start     = ($urandom_range(7, 0) == 0);
        prog_we   = ($urandom_range(3, 0) == 0);
        prog_addr = AW'($urandom);
        prog_data = (DW+4)'($urandom);
        reset     = ($urandom_range(47, 0) != 0);
        tick();
        check_all("rnd");
      end
      start = 1'b0; prog_we = 1'b0; reset = 1'b1;
    end
    in_data = '0;

    // Wide-parameter extensions
    tick();
    reset8 = 1'b1;
    chk("w.reset_pc", pc8, 0);
    chk("w.reset_run", run8, 0);
    load8('h00, 'h720); load8('h01, 'h3F0); load8('h02, 'h800); load8('h03, 'hC3C);
    load8('h3C, 'h400); load8('h3D, 'h900); load8('h3E, 'hFFF); load8('h3F, 'hA00);
    start8 = 1'b1; tick(); start8 = 1'b0;
    chk("w.start_pc", pc8, 0);
    chk("w.running", run8, 1);
    tick(); tick(); tick();
    chk("w.add_carry", carry8, 1);
    chk("w.add_pc", pc8, 3);
    tick();
    chk("w.jc_pc", pc8, 'h3C);
    chk("w.jc_clears_carry", carry8, 0);
    tick(); tick();
    chk("w.out_sum", out8, 'h10);
    chk("w.out_valid", outv8, 1);
    tick();
    chk("w.jmp_trunc", pc8, 'h3F);
    tick();
    chk("w.halted", halt8, 1);
    chk("w.halt_pc", pc8, 'h3F);
    check_all("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_td4x_core
`default_nettype wire
